// File: rtl/alu_cmd_driver.sv
// Command-side initiator for the registered ALU: issues one operation, waits out ALU_LAT, returns the result.
// Optional running accumulator for operand A is built only when ALU_CMD_ACC_EN is defined.
module alu_cmd_driver #(
  parameter int WIDTH   = 32,
  parameter int ALU_LAT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [2:0]       i_cmd_op,
  input  logic [WIDTH-1:0] i_cmd_dataA,
  input  logic [WIDTH-1:0] i_cmd_dataB,
  input  logic             i_cmd_useAcc,
  output logic [WIDTH-1:0] o_alu_dataA,
  output logic [WIDTH-1:0] o_alu_dataB,
  output logic             o_alu_m,
  output logic [1:0]       o_alu_sel,
  input  logic [WIDTH-1:0] i_alu_data,
  input  logic             i_alu_overflow,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_data,
  output logic             o_rsp_overflow,
  output logic             o_rsp_zero,
  output logic [WIDTH-1:0] o_acc
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [2:0] LAT_LD = 3'(ALU_LAT);

  state_t           state;
  logic [2:0]       cnt;
  logic [WIDTH-1:0] opa;
  logic             capture;

  // Only add (101) and subtract (110) produce a meaningful carry/borrow.
  function automatic logic ovf_mask(input logic m, input logic [1:0] sel, input logic ovf);
    return ovf & m & (sel[0] ^ sel[1]);
  endfunction

  assign capture = (state == S_WAIT) && (cnt == 3'd0);

`ifdef ALU_CMD_ACC_EN
  logic [WIDTH-1:0] acc_q;

  assign opa   = i_cmd_useAcc ? acc_q : i_cmd_dataA;
  assign o_acc = acc_q;

  always_ff @(posedge i_clk) begin
    if (i_rst)        acc_q <= '0;
    else if (capture) acc_q <= i_alu_data;
  end
`else
  logic unused_use_acc;

  assign unused_use_acc = i_cmd_useAcc;
  assign opa            = i_cmd_dataA;
  assign o_acc          = '0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      o_cmd_ready    <= 1'b1;
      o_rsp_valid    <= 1'b0;
      o_alu_dataA    <= '0;
      o_alu_dataB    <= '0;
      o_alu_m        <= 1'b0;
      o_alu_sel      <= '0;
      o_rsp_data     <= '0;
      o_rsp_overflow <= 1'b0;
      o_rsp_zero     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            o_alu_dataA          <= opa;
            o_alu_dataB          <= i_cmd_dataB;
            {o_alu_m, o_alu_sel} <= i_cmd_op;
            cnt                  <= LAT_LD;
            o_cmd_ready          <= 1'b0;
            state                <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (capture) begin
            o_rsp_data     <= i_alu_data;
            o_rsp_zero     <= (i_alu_data == '0);
            o_rsp_overflow <= ovf_mask(o_alu_m, o_alu_sel, i_alu_overflow);
            o_rsp_valid    <= 1'b1;
            state          <= S_RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_cmd_ready <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: begin
          state       <= S_IDLE;
          o_cmd_ready <= 1'b1;
          o_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Scoreboard bench for alu_cmd_driver: two instances (ALU_LAT=1 and 3), each driving a behavioural registered ALU.
`timescale 1ns/1ps
module tb_alu_cmd_driver;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] data;
    logic         ovf;
    logic         zero;
  } exp_t;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic         i_rst;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_a, cmd_b;
  logic         cmd_ua;
  logic         cv1, cv3, rr1, rr3;

  logic         cr1, am1, rv1, ro1, rz1, ao1;
  logic [1:0]   as1;
  logic [W-1:0] aA1, aB1, ad1, rd1, acc1;
  logic         cr3, am3, rv3, ro3, rz3, ao3;
  logic [1:0]   as3;
  logic [W-1:0] aA3, aB3, ad3, rd3, acc3;

  alu_cmd_driver #(.WIDTH(W), .ALU_LAT(1)) u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cmd_valid(cv1), .o_cmd_ready(cr1),
    .i_cmd_op(cmd_op), .i_cmd_dataA(cmd_a), .i_cmd_dataB(cmd_b), .i_cmd_useAcc(cmd_ua),
    .o_alu_dataA(aA1), .o_alu_dataB(aB1), .o_alu_m(am1), .o_alu_sel(as1),
    .i_alu_data(ad1), .i_alu_overflow(ao1), .o_rsp_valid(rv1), .i_rsp_ready(rr1),
    .o_rsp_data(rd1), .o_rsp_overflow(ro1), .o_rsp_zero(rz1), .o_acc(acc1));

  alu_cmd_driver #(.WIDTH(W), .ALU_LAT(3)) u_dut3 (
    .i_clk(i_clk), .i_rst(i_rst), .i_cmd_valid(cv3), .o_cmd_ready(cr3),
    .i_cmd_op(cmd_op), .i_cmd_dataA(cmd_a), .i_cmd_dataB(cmd_b), .i_cmd_useAcc(cmd_ua),
    .o_alu_dataA(aA3), .o_alu_dataB(aB3), .o_alu_m(am3), .o_alu_sel(as3),
    .i_alu_data(ad3), .i_alu_overflow(ao3), .o_rsp_valid(rv3), .i_rsp_ready(rr3),
    .o_rsp_data(rd3), .o_rsp_overflow(ro3), .o_rsp_zero(rz3), .o_acc(acc3));

  // Behavioural ALU; non add/sub ops raise a junk flag so the driver's masking is exercised.
  function automatic logic [W:0] alu_f(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'b000:  return {1'b1, ~a + 32'd1};
      3'b001:  return {1'b1, a & b};
      3'b010:  return {1'b1, a ^ b};
      3'b011:  return {1'b1, a | b};
      3'b100:  return {1'b1, a - 32'd1};
      3'b101:  return {1'b0, a} + {1'b0, b};
      3'b110:  return {(a < b), a - b};
      default: return {1'b1, a + 32'd1};
    endcase
  endfunction

  logic [W:0] p1;
  logic [W:0] p3 [3];
  always @(posedge i_clk) begin
    p1    <= alu_f({am1, as1}, aA1, aB1);
    p3[0] <= alu_f({am3, as3}, aA3, aB3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign ad1 = p1[W-1:0];
  assign ao1 = p1[W];
  assign ad3 = p3[2][W-1:0];
  assign ao3 = p3[2][W];

  bit           dsel;
  logic         m_cmd_ready, m_rsp_valid, m_rsp_ovf, m_rsp_zero;
  logic [W-1:0] m_rsp_data, m_acc, m_aluA, m_aluB;
  logic [2:0]   m_aluop;
  always_comb begin
    m_cmd_ready = dsel ? cr3 : cr1;
    m_rsp_valid = dsel ? rv3 : rv1;
    m_rsp_ovf   = dsel ? ro3 : ro1;
    m_rsp_zero  = dsel ? rz3 : rz1;
    m_rsp_data  = dsel ? rd3 : rd1;
    m_acc       = dsel ? acc3 : acc1;
    m_aluA      = dsel ? aA3 : aA1;
    m_aluB      = dsel ? aB3 : aB1;
    m_aluop     = dsel ? {am3, as3} : {am1, as1};
  end

  int           n_checks = 0;
  int           n_fail   = 0;
  exp_t         sb [$];
  logic [W-1:0] tb_acc [2];
  logic [W-1:0] last_opa;
  logic [2:0]   last_op;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_cv(input logic v);
    if (dsel) cv3 = v;
    else      cv1 = v;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    tb_acc[0] = '0;
    tb_acc[1] = '0;
    sb.delete();
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic ua);
    int           n;
    exp_t         e;
    logic [W-1:0] opa;
    logic [W:0]   r;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_ua = ua;
    set_cv(1'b1);
    n = 0;
    while (!m_cmd_ready && n < 20) begin
      @(posedge i_clk); #1; n++;
    end
    if (!m_cmd_ready) begin
      chk("accept_timeout", 32'(m_cmd_ready), 32'd1);
      set_cv(1'b0);
      return;
    end
    @(posedge i_clk); #1;
    set_cv(1'b0);
`ifdef ALU_CMD_ACC_EN
    opa = ua ? tb_acc[dsel] : a;
`else
    opa = a;
`endif
    r      = alu_f(op, opa, b);
    e.data = r[W-1:0];
    e.ovf  = (op == 3'b101 || op == 3'b110) ? r[W] : 1'b0;
    e.zero = (e.data == '0);
`ifdef ALU_CMD_ACC_EN
    tb_acc[dsel] = e.data;
`endif
    last_opa = opa;
    last_op  = op;
    sb.push_back(e);
    chk("alu_a", m_aluA, opa);
    chk("alu_b", m_aluB, b);
    chk("alu_op", 32'(m_aluop), 32'(op));
  endtask

  task automatic collect(input int hold, input bit bp_cmd);
    int   n;
    exp_t e;
    n = 0;
    while (!m_rsp_valid && n < 20) begin
      @(posedge i_clk); #1; n++;
    end
    chk("rsp_latency", 32'(n), dsel ? 32'd4 : 32'd2);
    if (!m_rsp_valid || sb.size() == 0) begin
      chk("rsp_present", 32'(m_rsp_valid && sb.size() != 0), 32'd1);
      return;
    end
    e = sb.pop_front();
    chk("rsp_data", m_rsp_data, e.data);
    chk("rsp_ovf", 32'(m_rsp_ovf), 32'(e.ovf));
    chk("rsp_zero", 32'(m_rsp_zero), 32'(e.zero));
    chk("rsp_cmd_ready", 32'(m_cmd_ready), 32'd0);
    if (bp_cmd) set_cv(1'b1);
    for (int i = 0; i < hold; i++) begin
      @(posedge i_clk); #1;
      chk("bp_valid", 32'(m_rsp_valid), 32'd1);
      chk("bp_data", m_rsp_data, e.data);
      chk("bp_cmd_ready", 32'(m_cmd_ready), 32'd0);
    end
    set_cv(1'b0);
    if (dsel) rr3 = 1'b1;
    else      rr1 = 1'b1;
    @(posedge i_clk); #1;
    rr1 = 1'b0; rr3 = 1'b0;
    chk("rsp_drop", 32'(m_rsp_valid), 32'd0);
    chk("ready_back", 32'(m_cmd_ready), 32'd1);
    chk("acc", m_acc, tb_acc[dsel]);
    if (bp_cmd) begin
      chk("ignored_cmd_a", m_aluA, last_opa);
      chk("ignored_cmd_op", 32'(m_aluop), 32'(last_op));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    dsel = 1'b0;
    cv1 = 1'b0; cv3 = 1'b0; rr1 = 1'b0; rr3 = 1'b0;
    cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_ua = 1'b0;
    do_reset();

    for (int d = 0; d < 2; d++) begin
      dsel = (d == 1);
      chk("rst_cmd_ready", 32'(m_cmd_ready), 32'd1);
      chk("rst_rsp_valid", 32'(m_rsp_valid), 32'd0);
      chk("rst_rsp_data", m_rsp_data, 32'd0);
      chk("rst_acc", m_acc, 32'd0);
      chk("rst_alu_a", m_aluA, 32'd0);
    end
    dsel = 1'b0;

    issue(3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    collect(0, 1'b0);
    issue(3'b110, 32'd5, 32'd7, 1'b0);
    collect(0, 1'b0);
    issue(3'b010, 32'h1234, 32'h1234, 1'b0);
    collect(0, 1'b0);

    do_reset();
    for (int i = 0; i < 3; i++) begin
      issue(3'b111, 32'd0, 32'd0, 1'b1);
      collect(0, 1'b0);
    end
`ifdef ALU_CMD_ACC_EN
    chk("acc_chain", m_acc, 32'd3);
`else
    chk("acc_chain", m_acc, 32'd0);
`endif

    issue(3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
    cmd_op = 3'b111; cmd_a = 32'h5555_5555; cmd_b = 32'h1; cmd_ua = 1'b0;
    collect(5, 1'b1);

    issue(3'b101, 32'd3, 32'd4, 1'b0);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    tb_acc[0] = '0; tb_acc[1] = '0;
    sb.delete();
    chk("midrst_rsp_valid", 32'(m_rsp_valid), 32'd0);
    chk("midrst_cmd_ready", 32'(m_cmd_ready), 32'd1);
    chk("midrst_acc", m_acc, 32'd0);
    chk("midrst_alu_a", m_aluA, 32'd0);
    chk("midrst_alu_b", m_aluB, 32'd0);
    chk("midrst_alu_op", 32'(m_aluop), 32'd0);
    seen = 0;
    repeat (8) begin
      @(posedge i_clk); #1;
      if (m_rsp_valid) seen++;
    end
    chk("midrst_no_rsp", 32'(seen), 32'd0);

    dsel = 1'b1;
    issue(3'b000, 32'd1, 32'd0, 1'b0);
    collect(0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
